if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Fetch-to-decode instruction queue between the instruction fetch unit and the decode stage of the MIPS core.
- Buffers {PC, instruction} pairs with valid/ready handshakes on both sides, so fetch keeps running while decode stalls.
- Flags instruction-fetch address errors (AdEL) per entry and supplies the PC+8 link address to decode.
- A synchronous flush discards all entries on a branch, jump or exception redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_BASE, 32'h0000_3000, first valid instruction address.
- IM_WORDS, 4096, instruction memory size in words; valid range is PC_BASE to PC_BASE+4*IM_WORDS-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  discard all stored entries.
- in_valid  input  1  fetch presents a pair.
- in_ready  output  1  queue can accept.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head.
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction.
- out_pc8  output  32  head PC + 8, the link address.
- out_adel  output  1  head entry has a fetch address error.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
- Reset: head=0, tail=0, count=0; out_valid=0, in_ready=1, out_adel=0, out_pc=0, out_instr=0, out_pc8=0. Reset overrides flush and all handshakes.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. A full queue refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0). The out_* signals show the head entry combinationally from storage.
- When empty, out_pc=0, out_instr=0 (NOP), out_pc8=0 and out_adel=0.
- Latency: a pair pushed at edge N appears at the outputs after edge N, so it is poppable in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Push only: count+1. Pop only: count-1. count never exceeds DEPTH and never goes below 0.
- Flush at an edge: head=tail=0 and count=0. Any same-cycle push or pop is ignored. in_ready is 1 in the following cycle.
- AdEL is computed at push time and stored per entry. It is set if in_pc[1:0]!=0, or in_pc<PC_BASE, or in_pc>=PC_BASE+4*IM_WORDS. Comparisons are 32-bit unsigned.
- An AdEL entry stores instruction 32'h0000_0000 in place of in_instr. Its PC is stored unchanged.
- out_pc8 = out_pc + 32'd8, modulo 2^32, with no overflow flag.
- Pushes while full and pops while empty have no effect. They cannot occur through the handshake, but the bench checks them.

Decomposition:
- Shared package (cpu_pkg):
  - PC_RESET = 32'h0000_3000.
  - INSTR_NOP = 32'h0.
  - Type if_entry_t = {pc[31:0], instr[31:0], adel}.
- Sub-module fetch_addr_check: combinational AdEL range and alignment check, also reused by the load/store unit. All pointer and counter logic stays in if_id_queue.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, out_instr=0.
- Push 0x3000/0x3C010001, 0x3004/0x34210002, 0x3008/0x00000000 with out_ready=0 → count=3, head pc=0x3000, out_pc8=0x3008. Then out_ready=1 for 3 cycles → pairs pop in order and out_valid drops after the third pop.
- Fill to DEPTH=4 with out_ready=0 → in_ready=0, and a fifth push is ignored. Then push+pop together: pop accepted, push refused; count goes 4→3, then in_ready=1.
- Continuous push and pop for 10 cycles (PCs 0x3000 to 0x3024) → count steady, order preserved across pointer wrap.
- Flush with count=3 and in_valid=1 in the same cycle → next cycle count=0, out_valid=0, and the flushed-cycle pair is absent.
- Push pc=0x3002, then pc=0x2FFC, then pc=0x7000 → each entry has out_adel=1 and out_instr=0. pc=0x6FFC → out_adel=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared by the MIPS fetch path and its consumers.
package cpu_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } if_entry_t;

    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational address-error check: misaligned word, or outside instruction memory.
module fetch_addr_check
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_BASE  = PC_RESET,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic [31:0] addr_i,
    output logic        adel_o
);

    // 33-bit limit so a memory ending at 4 GiB does not wrap to zero.
    localparam logic [32:0] LIMIT = {1'b0, PC_BASE} + (33'(IM_WORDS) << 2);

    assign adel_o = (addr_i[1:0] != 2'b00)
                 || (addr_i < PC_BASE)
                 || ({1'b0, addr_i} >= LIMIT);

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue of {PC, instruction, AdEL} entries with valid/ready on both sides.
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_BASE  = PC_RESET,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc8,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, in_adel;
    if_entry_t       wr_entry, head_entry;

    fetch_addr_check #(
        .PC_BASE  (PC_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_addr_check (
        .addr_i (in_pc),
        .adel_o (in_adel)
    );

    // in_ready depends only on stored occupancy, so a full queue refuses a push even while popping.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_entry.pc    = in_pc;
        wr_entry.instr = in_adel ? INSTR_NOP : in_instr;
        wr_entry.adel  = in_adel;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[tail_q] <= wr_entry;
    end

    assign head_entry = mem_q[head_q];
    assign out_pc     = out_valid ? head_entry.pc : 32'd0;
    assign out_instr  = out_valid ? head_entry.instr : INSTR_NOP;
    assign out_pc8    = out_valid ? link_addr(head_entry.pc) : 32'd0;
    assign out_adel   = out_valid && head_entry.adel;
    assign count      = count_q;

endmodule
